version_store_ctrl: RTL and testbench

//   Owns the four version slots feeding priorityRouter and drives its version0..3, dataIn0..3
//   and readVersion inputs. Commits writes by assigning monotonically increasing version tags,

---
 rtl/version_store_ctrl.sv | 129 ++++++++++++
 tb/tb_version_store_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/version_store_ctrl.sv
`timescale 1ns/1ps
// version_store_ctrl: four-slot versioned store in front of priorityRouter.
// Writes take the next version tag and replace the oldest slot; reads do an
// exact-match lookup through the router and return the result over a handshake.
module version_store_ctrl #(
   parameter int BLOCK_SIZE = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wrValid,
   output logic                  wrReady,
   input  logic [DATA_WIDTH-1:0] wrData,
   input  logic                  rdValid,
   output logic                  rdReady,
   input  logic [BLOCK_SIZE-1:0] rdVersion,
   output logic                  respValid,
   input  logic                  respReady,
   output logic                  respHit,
   output logic [DATA_WIDTH-1:0] respData,
   output logic [BLOCK_SIZE-1:0] curVersion,
   output logic [2:0]            slotCount,
   output logic [BLOCK_SIZE-1:0] version0,
   output logic [BLOCK_SIZE-1:0] version1,
   output logic [BLOCK_SIZE-1:0] version2,
   output logic [BLOCK_SIZE-1:0] version3,
   output logic [DATA_WIDTH-1:0] dataIn0,
   output logic [DATA_WIDTH-1:0] dataIn1,
   output logic [DATA_WIDTH-1:0] dataIn2,
   output logic [DATA_WIDTH-1:0] dataIn3,
   output logic [BLOCK_SIZE-1:0] readVersion,
   input  logic [DATA_WIDTH-1:0] dataOut
);

   typedef enum logic [1:0] {IDLE, LOOKUP, RESP} stateE;

   stateE                 state;
   stateE                 nextState;
   logic                  slotValid [4];
   logic [BLOCK_SIZE-1:0] slotTag   [4];
   logic [DATA_WIDTH-1:0] slotData  [4];
   logic [1:0]            wrPtr;
   logic                  wrFire;
   logic                  rdFire;
   logic                  hit;

   assign wrFire = wrValid && wrReady;
   assign rdFire = rdValid && rdReady;

   assign version0 = slotTag[0];
   assign version1 = slotTag[1];
   assign version2 = slotTag[2];
   assign version3 = slotTag[3];
   assign dataIn0  = slotData[0];
   assign dataIn1  = slotData[1];
   assign dataIn2  = slotData[2];
   assign dataIn3  = slotData[3];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state logic: one lookup cycle, then hold the response until consumed
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (rdFire) nextState = LOOKUP;
         LOOKUP:  nextState = RESP;
         RESP:    if (respReady) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Handshake outputs; writes are blocked only while the lookup samples the slots
   always_comb begin
      rdReady = (state == IDLE);
      wrReady = (state != LOOKUP);
   end

   // Hit is decided by the valid mask so stale tag-0 slots never match
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++)
         hit = hit | (slotValid[i] && (slotTag[i] == readVersion));
   end

   // Slot storage: commit overwrites the oldest slot with the next version tag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            slotValid[i] <= 1'b0;
            slotTag[i]   <= '0;
            slotData[i]  <= '0;
         end
         wrPtr      <= 2'd0;
         curVersion <= '0;
         slotCount  <= 3'd0;
      end else if (wrFire) begin
         slotValid[wrPtr] <= 1'b1;
         slotTag[wrPtr]   <= curVersion + BLOCK_SIZE'(1);
         slotData[wrPtr]  <= wrData;
         curVersion       <= curVersion + BLOCK_SIZE'(1);
         wrPtr            <= wrPtr + 2'd1;
         if (slotCount != 3'd4) slotCount <= slotCount + 3'd1;
      end
   end

   // Read path: latch the tag on accept, register the router result, hold until consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         readVersion <= '0;
         respValid   <= 1'b0;
         respHit     <= 1'b0;
         respData    <= '0;
      end else begin
         if (rdFire) readVersion <= rdVersion;
         if (state == LOOKUP) begin
            respValid <= 1'b1;
            respHit   <= hit;
            respData  <= hit ? dataOut : '0;
         end else if ((state == RESP) && respReady) begin
            respValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_version_store_ctrl.sv
`timescale 1ns/1ps
// Bench for version_store_ctrl: directed writes/reads, scoreboard-checked responses,
// with a behavioural priorityRouter driving dataOut.
module tb_version_store_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wrValid = 1'b0;
   logic        wrReady;
   logic [31:0] wrData = '0;
   logic        rdValid = 1'b0;
   logic        rdReady;
   logic [3:0]  rdVersion = '0;
   logic        respValid;
   logic        respReady = 1'b1;
   logic        respHit;
   logic [31:0] respData;
   logic [3:0]  curVersion;
   logic [2:0]  slotCount;
   logic [3:0]  version0, version1, version2, version3;
   logic [31:0] dataIn0, dataIn1, dataIn2, dataIn3;
   logic [3:0]  readVersion;
   logic [31:0] dataOut;

   int errors = 0;
   int checks = 0;
   logic [32:0] expQ[$];

   version_store_ctrl #(.BLOCK_SIZE(4), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
      .rdValid(rdValid), .rdReady(rdReady), .rdVersion(rdVersion),
      .respValid(respValid), .respReady(respReady), .respHit(respHit), .respData(respData),
      .curVersion(curVersion), .slotCount(slotCount),
      .version0(version0), .version1(version1), .version2(version2), .version3(version3),
      .dataIn0(dataIn0), .dataIn1(dataIn1), .dataIn2(dataIn2), .dataIn3(dataIn3),
      .readVersion(readVersion), .dataOut(dataOut)
   );

   always #5 clk = ~clk;

   // Router model: first slot whose tag equals the lookup tag
   always_comb begin
      dataOut = '0;
      if      (version0 == readVersion) dataOut = dataIn0;
      else if (version1 == readVersion) dataOut = dataIn1;
      else if (version2 == readVersion) dataOut = dataIn2;
      else if (version3 == readVersion) dataOut = dataIn3;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: pop and compare on every consumed response
   always @(negedge clk) begin
      if (respValid && respReady) begin
         if (expQ.size() == 0) begin
            chk("unexpectedResp", 64'(respValid), 64'(0));
         end else begin
            logic [32:0] e;
            e = expQ.pop_front();
            chk("respHit", 64'(respHit), 64'(e[32]));
            chk("respData", 64'(respData), 64'(e[31:0]));
         end
      end
   end

   task automatic doReset();
      rst = 1'b1; wrValid = 1'b0; rdValid = 1'b0; respReady = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      expQ.delete();
   endtask

   task automatic doWrite(input logic [31:0] d);
      int n = 0;
      wrValid = 1'b1; wrData = d;
      @(negedge clk);
      while (!wrReady && n < 20) begin @(negedge clk); n++; end
      if (!wrReady) chk("wrTimeout", 64'(wrReady), 64'(1));
      @(posedge clk); #1;
      wrValid = 1'b0;
   endtask

   // Issue a read, check the two-cycle latency, return one cycle after respValid rises
   task automatic doRead(input logic [3:0] tag, input logic expHit, input logic [31:0] expData);
      int n = 0;
      expQ.push_back({expHit, expData});
      rdValid = 1'b1; rdVersion = tag;
      @(negedge clk);
      while (!rdReady && n < 20) begin @(negedge clk); n++; end
      if (!rdReady) chk("rdTimeout", 64'(rdReady), 64'(1));
      @(posedge clk); #1;
      rdValid = 1'b0;
      @(negedge clk);
      chk("lookupRespValid", 64'(respValid), 64'(0));
      chk("lookupWrReady", 64'(wrReady), 64'(0));
      @(negedge clk);
      chk("respLatency", 64'(respValid), 64'(1));
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL globalTimeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // 1: reset state
      doReset();
      @(negedge clk);
      chk("rstRespValid", 64'(respValid), 64'(0));
      chk("rstCurVersion", 64'(curVersion), 64'(0));
      chk("rstSlotCount", 64'(slotCount), 64'(0));
      chk("rstRdReady", 64'(rdReady), 64'(1));
      chk("rstWrReady", 64'(wrReady), 64'(1));
      chk("rstVersions", 64'({version0, version1, version2, version3}), 64'(0));
      chk("rstDataIn", {dataIn0 | dataIn1, dataIn2 | dataIn3}, 64'(0));
      @(posedge clk); #1;

      // 2: three writes, read tag 2
      doWrite(32'hA0); doWrite(32'hA1); doWrite(32'hA2);
      chk("t2SlotCount", 64'(slotCount), 64'(3));
      chk("t2CurVersion", 64'(curVersion), 64'(3));
      doRead(4'd2, 1'b1, 32'hA1);
      chk("t2Drain", 64'(expQ.size()), 64'(0));

      // 3: five writes overwrite slot0; miss on evicted tag, hit on newest
      doReset();
      for (int i = 1; i <= 5; i++) doWrite(32'hB0 + 32'(i));
      chk("t3Version0", 64'(version0), 64'(5));
      chk("t3DataIn0", 64'(dataIn0), 64'hB5);
      chk("t3Version1", 64'(version1), 64'(2));
      chk("t3SlotCount", 64'(slotCount), 64'(4));
      doRead(4'd1, 1'b0, 32'h0);
      doRead(4'd5, 1'b1, 32'hB5);

      // 4: write held high across a read; same-cycle write is seen by the lookup
      expQ.push_back({1'b1, 32'hC0});
      wrValid = 1'b1; wrData = 32'hC0; rdValid = 1'b1; rdVersion = 4'd6;
      @(negedge clk);
      chk("t4IdleRdReady", 64'(rdReady), 64'(1));
      chk("t4IdleWrReady", 64'(wrReady), 64'(1));
      @(posedge clk); #1;
      rdValid = 1'b0;
      @(negedge clk);
      chk("t4LookupWrReady", 64'(wrReady), 64'(0));
      chk("t4LookupCur", 64'(curVersion), 64'(6));
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4RespWrReady", 64'(wrReady), 64'(1));
      chk("t4RespCur", 64'(curVersion), 64'(6));
      @(posedge clk); #1;
      wrValid = 1'b0;
      chk("t4CurAfter", 64'(curVersion), 64'(7));
      chk("t4Version2", 64'(version2), 64'(7));

      // 5: 17 writes, tag wrap
      doReset();
      for (int i = 1; i <= 17; i++) begin
         doWrite(32'hD0 + 32'(i));
         if (i == 15) chk("t5Cur15", 64'(curVersion), 64'(15));
         if (i == 16) chk("t5Cur16", 64'(curVersion), 64'(0));
         if (i == 17) chk("t5Cur17", 64'(curVersion), 64'(1));
      end
      doRead(4'd0, 1'b1, 32'hE0);
      doRead(4'd12, 1'b0, 32'h0);
      chk("t5Drain", 64'(expQ.size()), 64'(0));

      // 6: backpressure holds the response, then reset in RESP drops it
      respReady = 1'b0;
      doRead(4'd1, 1'b1, 32'hE1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6HoldValid", 64'(respValid), 64'(1));
         chk("t6HoldHit", 64'(respHit), 64'(1));
         chk("t6HoldData", 64'(respData), 64'hE1);
         chk("t6HoldRdReady", 64'(rdReady), 64'(0));
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expQ.delete();
      chk("t6RstRespValid", 64'(respValid), 64'(0));
      chk("t6RstRdReady", 64'(rdReady), 64'(1));
      chk("t6RstCur", 64'(curVersion), 64'(0));
      respReady = 1'b1;
      @(negedge clk);
      chk("t6IdleWrReady", 64'(wrReady), 64'(1));
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
